// File: rtl/user_io_router.sv
// Multi-channel GPIO pass-through: 2-flop synchroniser, glitch filter, inversion,
// edge counters and event pulse. Define USER_IO_ROUTER_EDGE_CNT_EN to build the edge counters.
module user_io_router #(
    parameter int unsigned CH     = 4,
    parameter int unsigned FILT_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic [CH-1:0]       in_i,
    input  logic [CH-1:0]       en_i,
    input  logic [CH-1:0]       inv_i,
    input  logic [FILT_W-1:0]   filt_len_i,
    input  logic                clr_i,
    output logic [CH-1:0]       out_o,
    output logic [CH-1:0]       oeb_o,
    output logic [CH*CNT_W-1:0] edge_cnt_o,
    output logic                irq_o
);

    logic [CH-1:0]     s1_q, s1_d;
    logic [CH-1:0]     s2_q, s2_d;
    logic [CH-1:0]     filt_q, filt_d;
    logic [FILT_W-1:0] fcnt_q [CH];
    logic [FILT_W-1:0] fcnt_d [CH];
    logic [CH-1:0]     rise_d;
    logic              irq_q, irq_d;

    // Synchroniser and glitch filter; a disabled channel is forced to its reset state.
    always_comb begin
        s1_d   = in_i;
        s2_d   = s1_q;
        filt_d = filt_q;
        rise_d = '0;
        for (int k = 0; k < int'(CH); k++) begin
            fcnt_d[k] = fcnt_q[k];
            if (s2_q[k] == filt_q[k]) begin
                fcnt_d[k] = '0;
            end else if (fcnt_q[k] >= filt_len_i) begin
                filt_d[k] = s2_q[k];
                fcnt_d[k] = '0;
            end else begin
                fcnt_d[k] = FILT_W'(fcnt_q[k] + FILT_W'(1));
            end
            if (!en_i[k]) begin
                s1_d[k]   = 1'b0;
                s2_d[k]   = 1'b0;
                filt_d[k] = 1'b0;
                fcnt_d[k] = '0;
            end
            rise_d[k] = en_i[k] & ~filt_q[k] & filt_d[k];
        end
        irq_d = |(en_i & (filt_q ^ filt_d));
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            filt_q <= '0;
            irq_q  <= 1'b0;
            for (int k = 0; k < int'(CH); k++) begin
                fcnt_q[k] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            irq_q  <= irq_d;
            for (int k = 0; k < int'(CH); k++) begin
                fcnt_q[k] <= fcnt_d[k];
            end
        end
    end

    assign out_o = en_i & (filt_q ^ inv_i);
    assign oeb_o = ~en_i;
    assign irq_o = irq_q;

`ifdef USER_IO_ROUTER_EDGE_CNT_EN
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];

    // Saturating rising-edge counters; clear has priority over an increment.
    always_comb begin
        edge_cnt_o = '0;
        for (int k = 0; k < int'(CH); k++) begin
            cnt_d[k] = cnt_q[k];
            if (!en_i[k] || clr_i) begin
                cnt_d[k] = '0;
            end else if (rise_d[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                cnt_d[k] = CNT_W'(cnt_q[k] + CNT_W'(1));
            end
            edge_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        for (int k = 0; k < int'(CH); k++) begin
            if (!wb_rstn_i) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = &{1'b0, clr_i, rise_d};
    assign edge_cnt_o        = '0;
`endif

endmodule
